// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute
// states, plus the combinational ALU decoder driven by the registered aluop.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memtoreg,
  output logic       regdst,
  output logic       lord,
  output logic       alusrca,
  output logic       irwrite,
  output logic       memwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic [1:0] pcsrc,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMRD    = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWR    = 4'd5;
  localparam logic [3:0] EXECUTE  = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] ADDIEXEC = 4'd9;
  localparam logic [3:0] ADDIWB   = 4'd10;
  localparam logic [3:0] JUMP     = 4'd11;

  typedef struct packed {
    logic       memtoreg;
    logic       regdst;
    logic       lord;
    logic       alusrca;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore output table; unknown state codes decode to all-zero controls.
  function automatic ctrl_t ctrl_of(input logic [3:0] s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
      DECODE:   c.alusrcb = 2'b11;
      MEMADR:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:    c.lord = 1'b1;
      MEMWB:    begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      MEMWR:    begin c.lord = 1'b1; c.memwrite = 1'b1; end
      EXECUTE:  begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      ALUWB:    begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BRANCH:   begin c.alusrca = 1'b1; c.pcsrc = 2'b01; c.branch = 1'b1; c.aluop = 2'b01; end
      ADDIEXEC: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      ADDIWB:   c.regwrite = 1'b1;
      JUMP:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  logic [3:0] state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;

  // Next-state selection; anything without a successor returns to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (op)
          6'b100011, 6'b101011: state_d = MEMADR;
          6'b000000:            state_d = EXECUTE;
          6'b000100:            state_d = BRANCH;
          6'b001000:            state_d = ADDIEXEC;
          6'b000010:            state_d = JUMP;
          default:              state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (op == 6'b100011) state_d = MEMRD;
        else                 state_d = MEMWR;
      end
      MEMRD:    state_d = MEMWB;
      EXECUTE:  state_d = ALUWB;
      ADDIEXEC: state_d = ADDIWB;
      default:  state_d = FETCH;
    endcase
    ctrl_d = ctrl_of(state_d);
  end

  // Controls are registered alongside the state so outputs never glitch on decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      ctrl_q  <= ctrl_of(FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // ALU decoder: funct only matters for R-type execution.
  always_comb begin
    alucontrol = 3'b010;
    case (ctrl_q.aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  assign memtoreg = ctrl_q.memtoreg;
  assign regdst   = ctrl_q.regdst;
  assign lord     = ctrl_q.lord;
  assign alusrca  = ctrl_q.alusrca;
  assign irwrite  = ctrl_q.irwrite;
  assign memwrite = ctrl_q.memwrite;
  assign regwrite = ctrl_q.regwrite;
  assign pcsrc    = ctrl_q.pcsrc;
  assign alusrcb  = ctrl_q.alusrcb;
  assign pcen     = ctrl_q.pcwrite | (ctrl_q.branch & zero);

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus pushes per-cycle expectations
// from an instruction-level model, a negedge monitor pops and compares.
module tb_mc_controller;

  logic       clk, reset, zero;
  logic [5:0] op, funct;
  logic       memtoreg, regdst, lord, alusrca, irwrite, memwrite, pcen, regwrite;
  logic [1:0] pcsrc, alusrcb;
  logic [2:0] alucontrol;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memtoreg(memtoreg), .regdst(regdst), .lord(lord), .alusrca(alusrca),
    .irwrite(irwrite), .memwrite(memwrite), .pcen(pcen), .regwrite(regwrite),
    .pcsrc(pcsrc), .alusrcb(alusrcb), .alucontrol(alucontrol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] exp_q[$];
  logic [18:0] mon_exp, mon_act;
  int checks = 0;
  int failures = 0;

  // ALU operation the R-type funct field selects.
  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected {state, controls, alucontrol} for one step of an instruction.
  function automatic logic [18:0] expect_of(input int step, input logic [5:0] f, input logic z);
    logic m2r, rd, lo, asa, irw, mw, pe, rw;
    logic [1:0] ps, asb;
    logic [2:0] ac;
    {m2r, rd, lo, asa, irw, mw, pe, rw} = 8'd0;
    ps = 2'b00; asb = 2'b00; ac = 3'b010;
    case (step)
      0:  begin irw = 1'b1; pe = 1'b1; asb = 2'b01; end
      1:  asb = 2'b11;
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  lo = 1'b1;
      4:  begin m2r = 1'b1; rw = 1'b1; end
      5:  begin lo = 1'b1; mw = 1'b1; end
      6:  begin asa = 1'b1; ac = rtype_alu(f); end
      7:  begin rd = 1'b1; rw = 1'b1; end
      8:  begin asa = 1'b1; ps = 2'b01; pe = z; ac = 3'b110; end
      9:  begin asa = 1'b1; asb = 2'b10; end
      10: rw = 1'b1;
      11: begin ps = 2'b10; pe = 1'b1; end
      default: ;
    endcase
    return {4'(step), m2r, rd, lo, asa, irw, mw, pe, rw, ps, asb, ac};
  endfunction

  // Monitor: every cycle the DUT presents a control word; compare it to the scoreboard head.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {dut.state_q, memtoreg, regdst, lord, alusrca, irwrite, memwrite,
                 pcen, regwrite, pcsrc, alusrcb, alucontrol};
      checks++;
      if (mon_act !== mon_exp) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t op=%b funct=%b zero=%b actual=%h required=%h",
                 $time, op, funct, zero, mon_act, mon_exp);
      end
    end
  end

  // Run one instruction; zmode 0/1 fixes zero, 2 randomizes it each cycle.
  // rst_at names a step index during which reset is pulsed between clock edges.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                           input int rst_at);
    int st[$];
    int i;
    case (o)
      6'b100011: st = '{0, 1, 2, 3, 4};
      6'b101011: st = '{0, 1, 2, 5};
      6'b000000: st = '{0, 1, 6, 7};
      6'b000100: st = '{0, 1, 8};
      6'b001000: st = '{0, 1, 9, 10};
      6'b000010: st = '{0, 1, 11};
      default:   st = '{0, 1};
    endcase
    op = o;
    funct = f;
    i = 0;
    while (i < st.size()) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      exp_q.push_back(expect_of(st[i], f, zero));
      if (i == rst_at) begin
        #6;
        reset = 1'b1;
        #1;
        checks++;
        if (memwrite !== 1'b0 || dut.state_q !== 4'd0 || irwrite !== 1'b1) begin
          failures++;
          $display("FAIL async_reset actual memwrite=%b state=%0d irwrite=%b required memwrite=0 state=0 irwrite=1",
                   memwrite, dut.state_q, irwrite);
        end
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        i = 1;
        rst_at = -1;
      end else begin
        @(posedge clk);
        #1;
        i++;
      end
    end
  endtask

  logic [5:0] op_tab[6];
  logic [5:0] fn_tab[5];
  logic [5:0] r_op, r_fn;

  initial begin
    op_tab = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    reset = 1'b0;
    op = 6'd0;
    funct = 6'd0;
    zero = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    exp_q.push_back(expect_of(0, 6'd0, 1'b0));
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(6'b100011, 6'($urandom), 2, -1);
    run_instr(6'b000000, 6'b101010, 2, -1);
    run_instr(6'b000100, 6'd0, 1, -1);
    run_instr(6'b000100, 6'd0, 0, -1);
    run_instr(6'b101011, 6'($urandom), 2, -1);
    run_instr(6'b101011, 6'($urandom), 2, 3);
    run_instr(6'b111111, 6'($urandom), 1, -1);
    run_instr(6'b000010, 6'($urandom), 2, -1);
    run_instr(6'b001000, 6'($urandom), 2, -1);
    run_instr(6'b000000, 6'b100100, 2, -1);
    run_instr(6'b000000, 6'b100101, 2, -1);
    run_instr(6'b000000, 6'b100010, 2, -1);
    run_instr(6'b000000, 6'b111111, 2, -1);

    for (int n = 0; n < 80; n++) begin
      int pick;
      pick = $urandom_range(0, 7);
      r_op = (pick < 6) ? op_tab[pick] : 6'($urandom);
      pick = $urandom_range(0, 6);
      r_fn = (pick < 5) ? fn_tab[pick] : 6'($urandom);
      run_instr(r_op, r_fn, 2, ($urandom_range(0, 9) == 0) ? 1 : -1);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
